// File: rtl/rmii_read_response_tx.sv
// rmii_read_response_tx: serializes registered bus read responses as minimum-size
// Ethernet II frames (header, 16-bit read data, zero pad, FCS) on the RMII TX pins.
//
// state    | meaning
// IDLE     | no frame; waiting for a read response
// PREAMBLE | 7 x 0x55 then SFD 0xD5 (32 dibits)
// DATA     | DST, SRC, EtherType, rdata, 44-byte pad (240 dibits), CRC accumulates
// FCS      | complemented CRC, LSB first (16 dibits)
// IFG      | inter-frame gap, line quiet (48 cycles)
module rmii_read_response_tx #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        txen,
  output logic [1:0]  txd,
  output logic        busy_o,
  output logic        dropped_o
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FCS, IFG} state_t;

  localparam logic [8:0]  PRE_LAST  = 9'd31;
  localparam logic [8:0]  DATA_LAST = 9'd239;
  localparam logic [8:0]  FCS_LAST  = 9'd15;
  localparam logic [8:0]  IFG_LAST  = 9'd47;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;

  state_t       state;
  logic [8:0]   cnt;
  logic [15:0]  active;
  logic [15:0]  pend;
  logic         pend_full;
  logic [31:0]  crc;

  logic         accept;
  logic         ifg_exit;
  logic         on_air;
  logic [8:0]   idx;
  logic [7:0]   cur_byte;
  logic [1:0]   dibit;
  logic [127:0] hdr;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 2; k++) begin
      if (r[0] ^ d[k]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    accept   = valid_i & ~rw_i;
    ifg_exit = (state == IFG) && (cnt == 9'd0);
    on_air   = (state == PREAMBLE) || (state == DATA) || (state == FCS);
    hdr      = {DST_MAC, SRC_MAC, ETHERTYPE, active};
    idx      = 9'd0;
    cur_byte = 8'h00;
    case (state)
      PREAMBLE: begin
        idx      = PRE_LAST - cnt;
        cur_byte = (idx[4:2] == 3'd7) ? 8'hD5 : 8'h55;
      end
      DATA: begin
        idx = DATA_LAST - cnt;
        // first 16 bytes come from the header word, the rest is zero pad
        if (idx[8:6] == 3'd0) cur_byte = hdr[{~idx[5:2], 3'b000} +: 8];
      end
      default: ;
    endcase
    case (idx[1:0])
      2'd0:    dibit = cur_byte[1:0];
      2'd1:    dibit = cur_byte[3:2];
      2'd2:    dibit = cur_byte[5:4];
      default: dibit = cur_byte[7:6];
    endcase
    if (state == FCS) dibit = ~crc[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 9'd0;
      active    <= 16'h0000;
      pend      <= 16'h0000;
      pend_full <= 1'b0;
      crc       <= 32'hFFFF_FFFF;
      txen      <= 1'b0;
      txd       <= 2'b00;
      busy_o    <= 1'b0;
      dropped_o <= 1'b0;
    end else begin
      txen      <= on_air;
      txd       <= on_air ? dibit : 2'b00;
      dropped_o <= 1'b0;
      if (accept && (state != IDLE) && !ifg_exit) begin
        if (!pend_full) begin
          pend      <= rdata_i;
          pend_full <= 1'b1;
        end else begin
          dropped_o <= 1'b1;
        end
      end
      case (state)
        IDLE: if (accept) begin
          active <= rdata_i;
          crc    <= 32'hFFFF_FFFF;
          cnt    <= PRE_LAST;
          state  <= PREAMBLE;
          busy_o <= 1'b1;
        end
        PREAMBLE: if (cnt == 9'd0) begin
          cnt   <= DATA_LAST;
          state <= DATA;
        end else cnt <= cnt - 9'd1;
        DATA: begin
          crc <= crc_dibit(crc, dibit);
          if (cnt == 9'd0) begin
            cnt   <= FCS_LAST;
            state <= FCS;
          end else cnt <= cnt - 9'd1;
        end
        FCS: begin
          crc <= crc >> 2;
          if (cnt == 9'd0) begin
            cnt   <= IFG_LAST;
            state <= IFG;
          end else cnt <= cnt - 9'd1;
        end
        IFG: begin
          if (cnt != 9'd0) begin
            cnt <= cnt - 9'd1;
          end else if (pend_full) begin
            // promote; a response arriving right now backfills the pending slot
            active    <= pend;
            pend      <= rdata_i;
            pend_full <= accept;
            crc       <= 32'hFFFF_FFFF;
            cnt       <= PRE_LAST;
            state     <= PREAMBLE;
          end else if (accept) begin
            active <= rdata_i;
            crc    <= 32'hFFFF_FFFF;
            cnt    <= PRE_LAST;
            state  <= PREAMBLE;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_read_response_tx.sv
// Bench for rmii_read_response_tx: decodes every frame on the RMII pins and compares it
// byte-for-byte with a frame built from Ethernet framing rules, plus timing checks.
module tb_rmii_read_response_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rdata_i = 16'h0000;
  logic        rw_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        txen;
  logic [1:0]  txd;
  logic        busy_o;
  logic        dropped_o;

  rmii_read_response_tx dut (
    .clk(clk), .rst_n(rst_n), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .txen(txen), .txd(txd), .busy_o(busy_o), .dropped_o(dropped_o)
  );

  always #10 clk = ~clk;

  typedef logic [7:0] frame_t [72];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reflected CRC-32 register (init all ones, no final complement) over a byte stream
  function automatic logic [31:0] crc_reg(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_frame(input logic [15:0] rd, output frame_t f);
    logic [47:0] dst;
    logic [47:0] src;
    logic [31:0] fcs;
    logic [7:0]  q[$];
    dst = 48'hFFFF_FFFF_FFFF;
    src = 48'h69_69_5A_06_54_91;
    for (int i = 0; i < 7; i++) f[i] = 8'h55;
    f[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      f[8 + i]  = dst[47 - 8*i -: 8];
      f[14 + i] = src[47 - 8*i -: 8];
    end
    f[20] = 8'h88;
    f[21] = 8'hB5;
    f[22] = rd[15:8];
    f[23] = rd[7:0];
    for (int i = 24; i < 68; i++) f[i] = 8'h00;
    for (int i = 8; i < 68; i++) q.push_back(f[i]);
    fcs = ~crc_reg(q);
    for (int i = 0; i < 4; i++) f[68 + i] = fcs[8*i +: 8];
  endtask

  logic [1:0]  dq[$];
  logic [15:0] exp_q[$];
  logic        prev_txen = 1'b0;
  logic        prev_busy = 1'b0;
  int low_run = 0, last_gap = -1, rise_cyc = -1, fall_cyc = -1, busy_fall_cyc = -1;
  int frames_done = 0, drop_cnt = 0, drop_cyc = -1;

  task automatic check_frame();
    frame_t      got, want;
    logic [7:0]  q[$];
    logic [15:0] rd;
    int          bad;
    chk("frame_len", dq.size(), 288);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got a frame, expected none (cycle %0d)", cyc);
    end else begin
      rd = exp_q.pop_front();
      build_frame(rd, want);
      for (int k = 0; k < 72; k++)
        got[k] = (4*k + 3 < dq.size()) ? {dq[4*k+3], dq[4*k+2], dq[4*k+1], dq[4*k]} : 8'hXX;
      bad = -1;
      for (int k = 0; k < 72; k++) if (bad < 0 && got[k] !== want[k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL frame_byte %0d (payload %h): got %h expected %h", bad, rd, got[bad], want[bad]);
      end
      for (int k = 8; k < 72; k++) q.push_back(got[k]);
      chk("fcs_residue", crc_reg(q), 32'hDEBB_20E3);
    end
    frames_done++;
    dq.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      dq.delete();
      prev_txen = 1'b0;
      prev_busy = 1'b0;
      low_run = 0;
    end else begin
      if (!txen) chk("txd_idle", {30'h0, txd}, 32'h0);
      if (dropped_o) begin
        drop_cnt++;
        drop_cyc = cyc;
      end
      if (prev_busy && !busy_o) busy_fall_cyc = cyc;
      prev_busy = busy_o;
      if (txen) begin
        if (!prev_txen) begin
          rise_cyc = cyc;
          last_gap = low_run;
        end
        dq.push_back(txd);
        low_run = 0;
      end else begin
        low_run++;
        if (prev_txen) begin
          fall_cyc = cyc;
          check_frame();
        end
      end
      prev_txen = txen;
    end
  end

  // called just after a rising edge; the response is sampled on the next edge
  task automatic pulse(input logic [15:0] d, input logic rw, output int acc);
    valid_i = 1'b1;
    rw_i    = rw;
    rdata_i = d;
    @(posedge clk);
    #1;
    acc     = cyc;
    valid_i = 1'b0;
    rw_i    = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("frame_timeout", frames_done >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("busy_timeout", busy_o, 0);
  endtask

  initial begin
    frame_t     mf;
    logic [7:0] q[$];
    int a0, a1, a2, f0, d0;
    logic bad_seen;

    // model pins
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    chk("model_crc_123456789", ~crc_reg(q), 32'hCBF4_3926);
    build_frame(16'hBEEF, mf);
    chk("model_sfd", mf[7], 8'hD5);
    chk("model_src0", mf[14], 8'h69);
    chk("model_etype", {mf[20], mf[21]}, 16'h88B5);
    chk("model_payload", {mf[22], mf[23]}, 16'hBEEF);
    q.delete();
    for (int i = 8; i < 72; i++) q.push_back(mf[i]);
    chk("model_residue", crc_reg(q), 32'hDEBB_20E3);

    // reset state
    repeat (3) @(posedge clk);
    #3;
    chk("rst_txen", txen, 0);
    chk("rst_txd", txd, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_dropped", dropped_o, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single read
    exp_q.push_back(16'hBEEF);
    pulse(16'hBEEF, 1'b0, a0);
    chk("busy_at_accept", busy_o, 1);
    wait_frames(1, 400);
    chk("first_dibit_latency", rise_cyc, a0 + 1);
    wait_idle(100);
    chk("busy_fall_after_ifg", busy_fall_cyc, fall_cyc + 47);

    // write is ignored
    @(posedge clk);
    #1;
    f0 = frames_done;
    d0 = drop_cnt;
    pulse(16'h1234, 1'b1, a0);
    bad_seen = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (txen || busy_o || dropped_o) bad_seen = 1'b1;
    end
    chk("write_no_activity", bad_seen, 0);
    chk("write_no_frame", frames_done, f0);
    @(posedge clk);
    #1;

    // two back-to-back reads
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    pulse(16'h0001, 1'b0, a0);
    pulse(16'h0002, 1'b0, a1);
    wait_frames(f0 + 2, 1000);
    chk("ifg_gap", last_gap, 48);
    chk("b2b_no_drop", drop_cnt, d0);
    wait_idle(100);
    @(posedge clk);
    #1;

    // three reads: third dropped
    f0 = frames_done;
    d0 = drop_cnt;
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0004);
    pulse(16'h0003, 1'b0, a0);
    pulse(16'h0004, 1'b0, a1);
    pulse(16'h0005, 1'b0, a2);
    wait_frames(f0 + 2, 1000);
    wait_idle(100);
    repeat (50) @(negedge clk);
    chk("drop_count", drop_cnt, d0 + 1);
    chk("drop_cycle", drop_cyc, a2);
    chk("only_two_frames", frames_done, f0 + 2);
    @(posedge clk);
    #1;

    // reset mid-frame
    exp_q.push_back(16'h1357);
    pulse(16'h1357, 1'b0, a0);
    repeat (100) @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_txen", txen, 0);
    chk("async_rst_txd", txd, 0);
    chk("async_rst_busy", busy_o, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    f0 = frames_done;
    exp_q.push_back(16'hA5A5);
    pulse(16'hA5A5, 1'b0, a0);
    wait_frames(f0 + 1, 400);
    chk("post_reset_latency", rise_cyc, a0 + 1);
    wait_idle(100);
    @(posedge clk);
    #1;

    // rdata change after accept must not alter the frame
    f0 = frames_done;
    exp_q.push_back(16'h00FF);
    pulse(16'h00FF, 1'b0, a0);
    rdata_i = 16'hFFFF;
    wait_frames(f0 + 1, 400);
    wait_idle(100);
    chk("no_leftover_expect", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
